// File: rtl/i2c_target_regs_pkg.sv
// i2c_target_regs_pkg: shared FSM states and bus-level constants for the I2C target
package i2c_target_regs_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } state_t;
  localparam logic I2C_ACK = 1'b0;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/i2c_target_regs_bus_sync.sv
// i2c_target_regs_bus_sync: pin synchronizers, SCL edge pulses and START/STOP detection
module i2c_target_regs_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [2:0] scl_r, sda_r;
  // Two sync stages then a previous-sample stage; reset to the idle-high bus level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_r <= '1;
      sda_r <= '1;
    end else begin
      scl_r <= {scl_r[1:0], scl_i};
      sda_r <= {sda_r[1:0], sda_i};
    end
  assign sda       = sda_r[1];
  assign scl_rise  = scl_r[1] & ~scl_r[2];
  assign scl_fall  = ~scl_r[1] & scl_r[2];
  assign start_det = scl_r[1] & scl_r[2] & ~sda_r[1] & sda_r[2];
  assign stop_det  = scl_r[1] & scl_r[2] & sda_r[1] & ~sda_r[2];
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with pointer-addressed byte register file and host read port
module i2c_target_regs import i2c_target_regs_pkg::*; #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int NUM_REGS = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_raddr,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic             busy
);
  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_t state;
  logic [7:0] shreg, byte_in;
  logic [2:0] bit_cnt;
  logic [PTR_W-1:0] ptr;
  logic [7:0] regs [NUM_REGS];

  i2c_target_regs_bus_sync u_sync (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda(sda_s),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );

  assign byte_in = {shreg[6:0], sda_s};

  // Protocol FSM: STOP/START override everything, bits in on SCL rise, SDA changes on SCL fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      ptr <= '0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state <= ST_IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (start_det) begin
        state <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe <= 1'b0;
        busy <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            shreg <= byte_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) state <= (byte_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
              else if (state == ST_PTR) begin
                ptr <= byte_in[PTR_W-1:0];
                state <= ST_PTR_ACK;
              end else begin
                regs[ptr] <= byte_in;
                wr_strobe <= 1'b1;
                wr_addr <= ptr;
                ptr <= ptr + 1'b1;
                state <= ST_WDATA_ACK;
              end
            end
          end
          ST_RDATA_ACK:
            if (sda_s == I2C_ACK) begin
              shreg <= regs[ptr];
              ptr <= ptr + 1'b1;
            end else state <= ST_IGNORE;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK:
            if (!sda_oe) sda_oe <= 1'b1;
            else begin
              bit_cnt <= '0;
              if (state == ST_ADDR_ACK && shreg[0] == RW_READ) begin
                shreg <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
                ptr <= ptr + 1'b1;
                state <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          ST_RDATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state <= ST_RDATA_ACK;
            end else begin
              shreg <= shreg << 1;
              sda_oe <= ~shreg[6];
            end
          end
          ST_RDATA_ACK: begin
            sda_oe <= ~shreg[7];
            bit_cnt <= '0;
            state <= ST_RDATA;
          end
          default: ;
        endcase
      end
    end

  // Registered host read; a same-cycle I2C write to that index shows up one cycle later
  always_ff @(posedge clk or posedge rst)
    if (rst) host_rdata <= '0;
    else host_rdata <= regs[host_raddr];
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master against the target with a register-file model
module tb_i2c_target_regs;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda_low = 1'b0;
  logic [3:0] host_raddr = '0;
  logic sda_i, sda_oe, wr_strobe, busy;
  logic [7:0] host_rdata;
  logic [3:0] wr_addr;

  assign sda_i = ~(m_sda_low | sda_oe);
  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_i), .sda_oe(sda_oe),
    .host_raddr(host_raddr), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .busy(busy)
  );

  int n_checks = 0, n_err = 0;
  logic [3:0] strobe_q[$];
  bit oe_seen;
  logic [7:0] mregs [16];
  int mp;
  logic [7:0] buf_d [8];
  logic acks [12];
  logic [7:0] rbuf [8];

  always @(negedge clk) begin
    if (wr_strobe) strobe_q.push_back(wr_addr);
    if (sda_oe) oe_seen <= 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit hit(input logic [7:0] ab);
    return ab[7:1] == 7'h50;
  endfunction

  task automatic bit_xfer(input logic b, output logic r);
    m_sda_low = ~b;
    clks(4);
    m_scl = 1'b1;
    clks(8);
    r = sda_i;
    m_scl = 1'b0;
    clks(4);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    clks(4);
    m_scl = 1'b1;
    clks(8);
    m_sda_low = 1'b1;
    clks(8);
    m_scl = 1'b0;
    clks(4);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    clks(4);
    m_scl = 1'b1;
    clks(8);
    m_sda_low = 1'b0;
    clks(8);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~ack, r);
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int n);
    logic a;
    logic [3:0] exp_q[$];
    strobe_q.delete();
    oe_seen = 1'b0;
    i2c_start();
    check("busy_after_start", busy, 1);
    send_byte(ab, a);
    acks[0] = a;
    send_byte(p, a);
    acks[1] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(buf_d[i], a);
      acks[i+2] = a;
    end
    i2c_stop();
    check("busy_after_stop", busy, 0);
    if (hit(ab)) begin
      mp = int'(p[3:0]);
      for (int i = 0; i < n; i++) begin
        mregs[mp] = buf_d[i];
        exp_q.push_back(4'(mp));
        mp = (mp + 1) % 16;
      end
    end
    for (int i = 0; i < n + 2; i++) check("w_ack", acks[i], hit(ab));
    check("w_nstrobe", strobe_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++) check("w_addr", strobe_q[i], exp_q[i]);
  endtask

  task automatic do_read(input logic [7:0] ab, input bit set_ptr, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d, e;
    i2c_start();
    if (set_ptr) begin
      send_byte({ab[7:1], 1'b0}, a);
      check("rp_addr_ack", a, hit(ab));
      send_byte(p, a);
      check("rp_ptr_ack", a, hit(ab));
      i2c_start();
      if (hit(ab)) mp = int'(p[3:0]);
    end
    send_byte(ab, a);
    check("r_addr_ack", a, hit(ab));
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i < n - 1);
      rbuf[i] = d;
      e = hit(ab) ? mregs[mp] : 8'hFF;
      if (hit(ab)) mp = (mp + 1) % 16;
      check("r_data", d, e);
    end
    check("r_oe_after_nack", sda_oe, 0);
    i2c_stop();
  endtask

  task automatic host_check(input logic [3:0] a, input logic [7:0] e);
    host_raddr = a;
    clks(1);
    check("host_rdata", host_rdata, e);
  endtask

  typedef struct {
    logic [7:0] ab, p, d0, d1;
    logic ack;
    int ns;
    logic [3:0] wa0, wa1;
  } wvec_t;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } hvec_t;

  initial begin
    wvec_t wv [3];
    hvec_t hv [5];
    logic r, a;
    logic [7:0] ab;
    logic [6:0] a7;
    int kind, n;
    wv[0] = '{8'hA0, 8'h03, 8'hA5, 8'h5A, 1'b1, 2, 4'd3, 4'd4};
    wv[1] = '{8'hA2, 8'h00, 8'hFF, 8'hFF, 1'b0, 0, 4'd0, 4'd0};
    wv[2] = '{8'hA0, 8'h0F, 8'h11, 8'h22, 1'b1, 2, 4'd15, 4'd0};
    hv[0] = '{4'd3, 8'hA5};
    hv[1] = '{4'd4, 8'h5A};
    hv[2] = '{4'd15, 8'h11};
    hv[3] = '{4'd0, 8'h22};
    hv[4] = '{4'd1, 8'h00};
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mp = 0;
    clks(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_host_rdata", host_rdata, 0);
    rst = 1'b0;
    clks(4);

    for (int k = 0; k < 3; k++) begin
      buf_d[0] = wv[k].d0;
      buf_d[1] = wv[k].d1;
      do_write(wv[k].ab, wv[k].p, 2);
      check("tbl_addr_ack", acks[0], wv[k].ack);
      check("tbl_oe_seen", oe_seen, wv[k].ack);
      check("tbl_nstrobe", strobe_q.size(), wv[k].ns);
      if (strobe_q.size() == 2 && wv[k].ns == 2) begin
        check("tbl_wa0", strobe_q[0], wv[k].wa0);
        check("tbl_wa1", strobe_q[1], wv[k].wa1);
      end
    end
    for (int k = 0; k < 5; k++) host_check(hv[k].a, hv[k].d);

    do_read(8'hA1, 1'b1, 8'h03, 2);
    check("read_byte0", rbuf[0], 8'hA5);
    check("read_byte1", rbuf[1], 8'h5A);

    strobe_q.delete();
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h05, a);
    mp = 5;
    for (int i = 0; i < 4; i++) bit_xfer(i[0], r);
    i2c_stop();
    check("abort_nstrobe", strobe_q.size(), 0);
    check("abort_busy", busy, 0);
    check("abort_sda_oe", sda_oe, 0);
    host_check(4'd5, mregs[5]);
    do_read(8'hA1, 1'b0, 8'h00, 1);

    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 4));
      a7 = 7'h50;
      if ($urandom_range(0, 5) == 0) begin
        do a7 = 7'($urandom); while (a7 == 7'h50);
      end
      for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
      ab = {a7, 1'b0};
      if (kind == 0) do_write(ab, 8'($urandom), n);
      else do_read({a7, 1'b1}, kind == 1, 8'($urandom), n);
    end
    for (int i = 0; i < 16; i++) host_check(4'(i), mregs[i]);

    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(1'(8'hA0 >> i), r);
    check("rst_pre_sda_oe", sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_sda_oe", sda_oe, 0);
    check("rst_async_busy", busy, 0);
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    clks(3);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mp = 0;
    clks(4);
    for (int i = 0; i < 16; i++) host_check(4'(i), mregs[i]);
    buf_d[0] = 8'h3C;
    do_write(8'hA0, 8'h07, 1);
    host_check(4'd7, 8'h3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
